// File: rtl/dma_pkg.sv
// Shared types and helpers for the device-to-host DMA write path.
package dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StFetch,
    StReq,
    StData
  } state_e;

  localparam int unsigned BoundaryBytes = 4096;

  // Device Control MPS field; reserved encodings fall back to 128 B.
  function automatic logic [12:0] mps_bytes(input logic [2:0] enc);
    logic [12:0] bytes;
    bytes = 13'd128;
    if (enc <= 3'd5) bytes = 13'd128 << enc;
    return bytes;
  endfunction

  function automatic logic [3:0] dwen_therm(input logic [1:0] dw_mod);
    logic [3:0] dwen;
    unique case (dw_mod)
      2'd1:    dwen = 4'b0001;
      2'd2:    dwen = 4'b0011;
      2'd3:    dwen = 4'b0111;
      default: dwen = 4'b1111;
    endcase
    return dwen;
  endfunction

endpackage

// File: rtl/dma_write_controller_if.sv
// Device-read and TX-write handshake bundle of the DMA write controller.
interface dma_write_controller_if;
  logic [31:0]  dev_rd_addr;
  logic         dev_rd_valid;
  logic         dev_rd_ready;
  logic [127:0] dev_rd_data;
  logic         dev_rd_data_valid;
  logic [31:0]  dma_write_addr;
  logic [9:0]   dma_write_len;
  logic         dma_write_valid;
  logic         dma_write_done;
  logic [127:0] dma_write_data;
  logic [3:0]   dma_write_data_dwen;
  logic         dma_write_data_valid;
  logic         dma_write_data_ready;

  modport master (
    output dev_rd_addr, dev_rd_valid,
    input  dev_rd_ready, dev_rd_data, dev_rd_data_valid,
    output dma_write_addr, dma_write_len, dma_write_valid,
    input  dma_write_done,
    output dma_write_data, dma_write_data_dwen, dma_write_data_valid,
    input  dma_write_data_ready
  );

  modport slave (
    input  dev_rd_addr, dev_rd_valid,
    output dev_rd_ready, dev_rd_data, dev_rd_data_valid,
    input  dma_write_addr, dma_write_len, dma_write_valid,
    output dma_write_done,
    input  dma_write_data, dma_write_data_dwen, dma_write_data_valid,
    output dma_write_data_ready
  );
endinterface

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module fifo #(
  parameter int unsigned BITS_DEPTH = 6,
  parameter int unsigned BITS_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [BITS_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [BITS_WIDTH-1:0] rd_data_o,
  output logic [BITS_DEPTH:0]   elements_o
);
  localparam int unsigned Depth = 1 << BITS_DEPTH;
  localparam int unsigned CntW  = BITS_DEPTH + 1;

  logic [BITS_WIDTH-1:0] mem_q [Depth];
  logic [BITS_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_wr, do_rd;

  assign do_wr = wr_en_i && (count_q != CntW'(Depth));
  assign do_rd = rd_en_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + BITS_DEPTH'(do_wr);
    rd_ptr_d = rd_ptr_q + BITS_DEPTH'(do_rd);
    count_d  = count_q + CntW'(do_wr) - CntW'(do_rd);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign elements_o = count_q;
endmodule

// File: rtl/dma_write_controller.sv
// Device-to-host DMA engine: fetches device beats into a buffer, then emits
// MPS- and 4 KB-bounded memory-write requests with their payload.
module dma_write_controller
  import dma_pkg::*;
#(
  parameter int unsigned BUF_DEPTH_BITS  = 6,
  parameter int unsigned MAX_PAYLOAD_CAP = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] pcie_dcommand,
  input  logic [31:0] dma_write_host_address,
  input  logic [31:0] dma_write_device_address,
  input  logic [31:0] dma_write_length,
  input  logic        dma_write_start,
  output logic        dma_write_busy,
  output logic        dma_write_finished,
  dma_write_controller_if.master bus
);
  localparam int unsigned Depth = 1 << BUF_DEPTH_BITS;
  localparam int unsigned CntW  = BUF_DEPTH_BITS + 1;
  localparam logic [31:0] CapBytes = 32'(MAX_PAYLOAD_CAP);

  state_e        state_q, state_d;
  logic [31:0]   host_addr_q, host_addr_d, dev_addr_q, dev_addr_d;
  logic [31:0]   remaining_q, remaining_d, rd_addr_q, rd_addr_d;
  logic [12:0]   chunk_q, chunk_d;
  logic [8:0]    beats_q, beats_d, issued_q, issued_d;
  logic [8:0]    rcvd_q, rcvd_d, sent_q, sent_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic          rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic          data_valid_q, data_valid_d, busy_q, busy_d, finished_q, finished_d;

  logic          rd_accept, rsp_in, pop;
  logic [31:0]   mps_full, eff_mps, to_boundary, chunk_calc;
  logic [12:0]   beats_sum;
  logic [127:0]  fifo_rdata;
  logic [CntW-1:0] fifo_elements;
  logic          unused_bits;

  assign rd_accept = rd_valid_q && bus.dev_rd_ready;
  // Responses outside FETCH cannot belong to the current transfer.
  assign rsp_in    = (state_q == StFetch) && bus.dev_rd_data_valid;
  assign pop       = data_valid_q && bus.dma_write_data_ready;

  assign mps_full    = 32'(mps_bytes(pcie_dcommand[7:5]));
  assign eff_mps     = (mps_full < CapBytes) ? mps_full : CapBytes;
  assign to_boundary = 32'(BoundaryBytes) - {20'd0, host_addr_q[11:0]};

  always_comb begin
    chunk_calc = remaining_q;
    if (eff_mps < chunk_calc) chunk_calc = eff_mps;
    if (to_boundary < chunk_calc) chunk_calc = to_boundary;
  end

  assign beats_sum   = chunk_calc[12:0] + 13'd15;
  assign unused_bits = ^{chunk_calc[31:13], beats_sum[3:0], pcie_dcommand[15:8],
                         pcie_dcommand[4:0]};

  fifo #(
    .BITS_DEPTH(BUF_DEPTH_BITS),
    .BITS_WIDTH(128)
  ) u_buf (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wr_en_i   (rsp_in),
    .wr_data_i (bus.dev_rd_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .elements_o(fifo_elements)
  );

  always_comb begin
    state_d      = state_q;
    host_addr_d  = host_addr_q;
    dev_addr_d   = dev_addr_q;
    remaining_d  = remaining_q;
    rd_addr_d    = rd_addr_q;
    chunk_d      = chunk_q;
    beats_d      = beats_q;
    issued_d     = issued_q;
    rcvd_d       = rcvd_q;
    sent_d       = sent_q;
    inflight_d   = inflight_q;
    rd_valid_d   = rd_valid_q;
    wr_valid_d   = wr_valid_q;
    data_valid_d = data_valid_q;
    busy_d       = busy_q;
    finished_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dma_write_start) begin
          host_addr_d = dma_write_host_address;
          dev_addr_d  = dma_write_device_address;
          remaining_d = dma_write_length;
          if (dma_write_length == '0) begin
            finished_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        chunk_d    = chunk_calc[12:0];
        beats_d    = beats_sum[12:4];
        issued_d   = '0;
        rcvd_d     = '0;
        sent_d     = '0;
        inflight_d = '0;
        rd_addr_d  = dev_addr_q;
        rd_valid_d = 1'b1;
        state_d    = StFetch;
      end
      StFetch: begin
        issued_d   = issued_q + 9'(rd_accept);
        rcvd_d     = rcvd_q + 9'(rsp_in);
        inflight_d = inflight_q + CntW'(rd_accept) - CntW'(rsp_in);
        if (rd_accept) rd_addr_d = rd_addr_q + 32'd16;
        // Credit: buffered plus outstanding beats must stay below buffer depth.
        rd_valid_d = (issued_d < beats_q) &&
                     ((32'(fifo_elements) + 32'(inflight_q) + 32'(rd_accept)) < 32'(Depth));
        if (rcvd_d == beats_q) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (bus.dma_write_done) begin
          wr_valid_d   = 1'b0;
          data_valid_d = 1'b1;
          state_d      = StData;
        end
      end
      StData: begin
        if (pop) begin
          sent_d = sent_q + 9'd1;
          if (sent_d == beats_q) begin
            data_valid_d = 1'b0;
            host_addr_d  = host_addr_q + {19'd0, chunk_q};
            dev_addr_d   = dev_addr_q + {19'd0, beats_q, 4'd0};
            remaining_d  = remaining_q - {19'd0, chunk_q};
            if (remaining_d == '0) begin
              finished_d = 1'b1;
              busy_d     = 1'b0;
              state_d    = StIdle;
            end else begin
              state_d = StCalc;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      host_addr_q  <= '0;
      dev_addr_q   <= '0;
      remaining_q  <= '0;
      rd_addr_q    <= '0;
      chunk_q      <= '0;
      beats_q      <= '0;
      issued_q     <= '0;
      rcvd_q       <= '0;
      sent_q       <= '0;
      inflight_q   <= '0;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      host_addr_q  <= host_addr_d;
      dev_addr_q   <= dev_addr_d;
      remaining_q  <= remaining_d;
      rd_addr_q    <= rd_addr_d;
      chunk_q      <= chunk_d;
      beats_q      <= beats_d;
      issued_q     <= issued_d;
      rcvd_q       <= rcvd_d;
      sent_q       <= sent_d;
      inflight_q   <= inflight_d;
      rd_valid_q   <= rd_valid_d;
      wr_valid_q   <= wr_valid_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
    end
  end

  assign dma_write_busy           = busy_q;
  assign dma_write_finished       = finished_q;
  assign bus.dev_rd_addr          = rd_addr_q;
  assign bus.dev_rd_valid         = rd_valid_q;
  assign bus.dma_write_addr       = host_addr_q;
  assign bus.dma_write_len        = chunk_q[11:2];
  assign bus.dma_write_valid      = wr_valid_q;
  assign bus.dma_write_data       = data_valid_q ? fifo_rdata : '0;
  assign bus.dma_write_data_valid = data_valid_q;
  assign bus.dma_write_data_dwen  = !data_valid_q             ? 4'b0000 :
                                    (sent_q == beats_q - 9'd1) ? dwen_therm(chunk_q[3:2]) :
                                                                 4'b1111;
endmodule

// File: tb/tb_dma_write_controller.sv
// Scoreboard bench for dma_write_controller with a transfer-level reference model.
module tb_dma_write_controller;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] pcie_dcommand;
  logic [31:0] dma_write_host_address, dma_write_device_address, dma_write_length;
  logic        dma_write_start, dma_write_busy, dma_write_finished;

  dma_write_controller_if bus ();

  dma_write_controller #(
    .BUF_DEPTH_BITS (6),
    .MAX_PAYLOAD_CAP(512)
  ) dut (
    .i_clk                   (i_clk),
    .i_rst                   (i_rst),
    .pcie_dcommand           (pcie_dcommand),
    .dma_write_host_address  (dma_write_host_address),
    .dma_write_device_address(dma_write_device_address),
    .dma_write_length        (dma_write_length),
    .dma_write_start         (dma_write_start),
    .dma_write_busy          (dma_write_busy),
    .dma_write_finished      (dma_write_finished),
    .bus                     (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, passes = 0, cycle = 0;
  bit mon_en = 1'b0, rnd = 1'b0;
  bit any_rd_valid, any_wr_valid;
  int beats_allowed = 0, outstanding = 0, fin_cnt = 0, hdr_seen = 0, beats_seen = 0;

  int unsigned  exp_hdr_addr[$], exp_hdr_len[$], exp_hdr_beats[$], exp_rd_addr[$];
  logic [127:0] exp_beat_data[$];
  logic [3:0]   exp_beat_dwen[$];
  int unsigned  rsp_addr[$], rsp_due[$];

  always @(posedge i_clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + 32'd8, ~a, a};
  endfunction

  function automatic logic [255:0] all_outs();
    return 256'({dma_write_busy, dma_write_finished, bus.dev_rd_addr, bus.dev_rd_valid,
                 bus.dma_write_addr, bus.dma_write_len, bus.dma_write_valid,
                 bus.dma_write_data, bus.dma_write_data_dwen, bus.dma_write_data_valid});
  endfunction

  // Transfer-level model: split into requests by MPS and 4 KB rules.
  task automatic model_transfer(input int unsigned host, dev, len, enc,
                                output int unsigned nhdr);
    int unsigned mps, rem, h, d, chunk, nb, dwn;
    mps = (enc <= 5) ? (128 << enc) : 128;
    if (mps > 512) mps = 512;
    rem = len; h = host; d = dev; nhdr = 0;
    while (rem > 0) begin
      chunk = rem;
      if (mps < chunk) chunk = mps;
      if (4096 - (h % 4096) < chunk) chunk = 4096 - (h % 4096);
      nb = (chunk + 15) / 16;
      exp_hdr_addr.push_back(h);
      exp_hdr_len.push_back((chunk / 4) % 1024);
      exp_hdr_beats.push_back(nb);
      for (int i = 0; i < int'(nb); i++) begin
        exp_rd_addr.push_back(d + 16 * i);
        exp_beat_data.push_back(pat(d + 16 * i));
        dwn = 4;
        if (i == int'(nb) - 1 && (chunk / 4) % 4 != 0) dwn = (chunk / 4) % 4;
        exp_beat_dwen.push_back(4'((1 << dwn) - 1));
      end
      h += chunk; d += 16 * nb; rem -= chunk; nhdr++;
    end
  endtask

  task automatic flush();
    exp_hdr_addr.delete(); exp_hdr_len.delete(); exp_hdr_beats.delete();
    exp_rd_addr.delete(); exp_beat_data.delete(); exp_beat_dwen.delete();
    rsp_addr.delete(); rsp_due.delete();
    beats_allowed = 0; outstanding = 0;
  endtask

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (bus.dev_rd_valid) any_rd_valid = 1'b1;
      if (bus.dma_write_valid) any_wr_valid = 1'b1;
      if (bus.dev_rd_valid && bus.dev_rd_ready) begin
        if (exp_rd_addr.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", bus.dev_rd_addr, exp_rd_addr.pop_front());
        rsp_addr.push_back(bus.dev_rd_addr);
        rsp_due.push_back(cycle + 1 + (rnd ? $urandom_range(0, 20) : 2));
        outstanding++;
        check("credit", outstanding <= 64, 1);
      end
      if (bus.dma_write_valid && bus.dma_write_done) begin
        if (exp_hdr_addr.size() == 0) check("hdr_extra", 1, 0);
        else begin
          check("hdr_addr", bus.dma_write_addr, exp_hdr_addr.pop_front());
          check("hdr_len", bus.dma_write_len, exp_hdr_len.pop_front());
          beats_allowed += exp_hdr_beats.pop_front();
        end
        hdr_seen++;
      end
      if (bus.dma_write_data_valid && bus.dma_write_data_ready) begin
        check("beat_gate", beats_allowed > 0, 1);
        beats_allowed--; outstanding--; beats_seen++;
        if (exp_beat_data.size() == 0) check("beat_extra", 1, 0);
        else begin
          check("beat_data", bus.dma_write_data, exp_beat_data.pop_front());
          check("beat_dwen", bus.dma_write_data_dwen, exp_beat_dwen.pop_front());
        end
      end
      if (dma_write_finished) fin_cnt++;
    end
  end

  // Device memory: in-order responses after a per-request latency
  initial begin
    bus.dev_rd_data_valid = 1'b0;
    bus.dev_rd_data = '0;
    forever begin
      @(posedge i_clk); #1;
      bus.dev_rd_data_valid = 1'b0;
      if (rsp_addr.size() > 0 && cycle >= int'(rsp_due[0])) begin
        void'(rsp_due.pop_front());
        bus.dev_rd_data = pat(rsp_addr.pop_front());
        bus.dev_rd_data_valid = 1'b1;
      end
    end
  end

  initial begin
    bus.dev_rd_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      bus.dev_rd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    bus.dma_write_data_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      bus.dma_write_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int hdr_delay;
    hdr_delay = 1;
    bus.dma_write_done = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (bus.dma_write_done) begin
        bus.dma_write_done = 1'b0;
        hdr_delay = rnd ? $urandom_range(0, 4) : 1;
      end else if (bus.dma_write_valid) begin
        if (hdr_delay == 0) bus.dma_write_done = 1'b1;
        else hdr_delay--;
      end
    end
  end

  task automatic run(input int unsigned host, dev, len, enc, input bit poke);
    int unsigned nhdr;
    int fin0, hdr0, budget;
    logic [2:0] enc3;
    model_transfer(host, dev, len, enc, nhdr);
    fin0 = fin_cnt; hdr0 = hdr_seen; enc3 = enc[2:0];
    @(posedge i_clk); #1;
    pcie_dcommand = {8'h00, enc3, 5'h00};
    dma_write_host_address = host;
    dma_write_device_address = dev;
    dma_write_length = len;
    dma_write_start = 1'b1;
    @(posedge i_clk); #1;
    dma_write_start = 1'b0;
    @(negedge i_clk);
    check("busy_start", dma_write_busy, 1);
    if (poke) begin
      @(posedge i_clk); #1;
      dma_write_host_address = 32'h0; dma_write_length = 32'd64; dma_write_start = 1'b1;
      @(posedge i_clk); #1;
      dma_write_start = 1'b0;
    end
    budget = 20000;
    while (fin_cnt == fin0 && budget > 0) begin
      @(negedge i_clk);
      budget--;
    end
    if (budget == 0) check("timeout", 0, 1);
    repeat (2) @(negedge i_clk);
    check("finished_count", fin_cnt - fin0, 1);
    check("busy_after", dma_write_busy, 0);
    check("hdr_count", hdr_seen - hdr0, nhdr);
    check("left_hdr", exp_hdr_addr.size(), 0);
    check("left_beats", exp_beat_data.size(), 0);
    check("left_rd", exp_rd_addr.size(), 0);
    flush();
  endtask

  initial begin
    int fin0, b0, budget;
    i_rst = 1'b1;
    pcie_dcommand = '0;
    dma_write_host_address = '0;
    dma_write_device_address = '0;
    dma_write_length = '0;
    dma_write_start = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_outputs", all_outs(), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    mon_en = 1'b1;

    run(32'h1000, 32'h0, 256, 0, 1'b0);
    run(32'h0FF0, 32'h100, 64, 2, 1'b0);
    run(32'h2000, 32'h400, 20, 2, 1'b0);

    // Zero-length transfer
    any_rd_valid = 1'b0; any_wr_valid = 1'b0; fin0 = fin_cnt;
    @(posedge i_clk); #1;
    dma_write_length = 32'd0; dma_write_start = 1'b1;
    @(posedge i_clk); #1;
    dma_write_start = 1'b0;
    @(negedge i_clk);
    check("len0_finished", dma_write_finished, 1);
    check("len0_busy", dma_write_busy, 0);
    repeat (5) @(negedge i_clk);
    check("len0_no_rd", any_rd_valid, 0);
    check("len0_no_wr", any_wr_valid, 0);
    check("len0_fin_count", fin_cnt - fin0, 1);

    rnd = 1'b1;
    run(32'h0001_0000, 32'h0002_0000, 4096, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run($urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFF0,
          $urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFF0,
          $urandom_range(1, 400) * 4, $urandom_range(0, 7), 1'b0);
    end
    rnd = 1'b0;

    // Reset during the first chunk's payload
    begin
      int unsigned nh;
      model_transfer(32'h3000, 32'h800, 256, 0, nh);
    end
    @(posedge i_clk); #1;
    pcie_dcommand = 16'h0000;
    dma_write_host_address = 32'h3000; dma_write_device_address = 32'h800;
    dma_write_length = 32'd256; dma_write_start = 1'b1;
    @(posedge i_clk); #1;
    dma_write_start = 1'b0;
    b0 = beats_seen; budget = 2000;
    while (beats_seen == b0 && budget > 0) begin
      @(negedge i_clk);
      budget--;
    end
    if (budget == 0) check("timeout", 0, 1);
    @(posedge i_clk); #1;
    i_rst = 1'b1; mon_en = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("reset_mid", all_outs(), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    flush();
    for (int i = 0; i < 3; i++) begin
      rsp_addr.push_back(32'h0000_BAD0 + 16 * i);
      rsp_due.push_back(0);
    end
    repeat (8) @(posedge i_clk);
    mon_en = 1'b1;
    run(32'h5000, 32'h900, 64, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dma_write_controller.md
Name: dma_write_controller

Overview:
Device-to-host DMA engine, the write-direction counterpart of the DMA read path. Takes a host address, device address and byte length, fetches data from device memory in 128-bit beats, and buffers it. Splits the transfer into PCIe memory-write requests that respect Max Payload Size and 4 KB host boundaries. Streams each request's payload to the TX engine with per-beat DW enables.

Parameters:
BUF_DEPTH_BITS, 6, log2 of payload buffer depth in 128-bit beats (64 beats = 1024 B).
MAX_PAYLOAD_CAP, 512, hard cap on request payload in bytes; power of two, 128..4096; must be <= 16*2^BUF_DEPTH_BITS.

Ports:
i_clk  in  1  clock; single clock domain.
i_rst  in  1  reset; synchronous, active-high.
pcie_dcommand  in  16  PCIe Device Control; [7:5] MPS encoding.
dma_write_host_address  in  32  host start byte address; 16-byte aligned.
dma_write_device_address  in  32  device start byte address; 16-byte aligned.
dma_write_length  in  32  bytes; multiple of 4.
dma_write_start  in  1  1-cycle start pulse.
dma_write_busy  out  1  high from start acceptance until the finished pulse.
dma_write_finished  out  1  1-cycle pulse when the last payload beat is accepted.
dev_rd_addr  out  32  device read address (16-byte beat address).
dev_rd_valid  out  1  device read request valid.
dev_rd_ready  in  1  device accepts the request when valid&&ready.
dev_rd_data  in  128  read response beat; DW0 in [31:0].
dev_rd_data_valid  in  1  response valid; in order, one beat per accepted request, arbitrary latency, no backpressure.
dma_write_addr  out  32  host address of the current write request.
dma_write_len  out  10  payload length in DW; 1024 is encoded as 0.
dma_write_valid  out  1  header request; held until dma_write_done.
dma_write_done  in  1  1-cycle pulse: TX engine accepted the header.
dma_write_data  out  128  payload beat.
dma_write_data_dwen  out  4  thermometer DW enable: 0001/0011/0111/1111.
dma_write_data_valid  out  1  payload beat valid.
dma_write_data_ready  in  1  beat transfers when valid&&ready.

Behaviour:
- Reset: all outputs 0; state IDLE; buffer flushed; outstanding-response counter cleared.
- MPS bytes = 128<<enc for enc 0..5; enc 6/7 is treated as 128. Effective MPS = min(MPS, MAX_PAYLOAD_CAP).
- IDLE: start latches host_addr, dev_addr and remaining=length, and sets busy on the next edge. Start is ignored while busy. If length==0, finished pulses the cycle after start, busy stays 0, and no requests are issued.
- CALC (1 cycle): chunk = min(remaining, effective MPS, 4096-host_addr[11:0]); beats = ceil(chunk/16). Proceeds to FETCH.
- FETCH: issues `beats` device reads at dev_addr, dev_addr+16, ... Requests are issued only while (buffer occupancy + in-flight responses) < depth.
  - Every dev_rd_data_valid beat is written to the buffer.
  - Leaves FETCH when all `beats` responses have arrived.
  - First dev_rd_valid is asserted the cycle after CALC.
- REQ: dma_write_valid=1, addr=host_addr, len=chunk/4 (low 10 bits). Addr and len are stable while valid. On dma_write_done, valid drops the next cycle and the state moves to DATA. dma_write_data_valid is never asserted before done.
- DATA: pops one buffer beat per valid&&ready. dwen=1111 except the chunk's last beat, which gets thermometer (chunk/4 mod 4); 0 maps to 1111. Data is not realigned.
- On the last beat: host_addr += chunk, dev_addr += beats*16, remaining -= chunk.
  - If remaining==0: pulse finished, clear busy, go to IDLE.
  - Otherwise go to CALC.
- Buffer never overflows, because requests are gated by credit. dev_rd_data_valid while IDLE (stale after reset) is dropped.
- Arithmetic is 32-bit and unsigned. Host address wrap past 2^32 is not supported; it is the caller's responsibility.
- Reset mid-operation: immediate return to IDLE; any partial request or data is abandoned.

Decomposition:
- Shared package `dma_pkg`: state enum (IDLE, CALC, FETCH, REQ, DATA), MPS decode function, dwen thermometer function, 4 KB boundary constant.
- Payload buffer: instantiate the existing `fifo` module (BITS_DEPTH=BUF_DEPTH_BITS, BITS_WIDTH=128). Its `elements` output feeds the credit check.
- No further sub-module.

Test Plan:
- MPS enc 0, host 0x1000, dev 0x0, len 256 -> requests (0x1000, len 32) and (0x1080, len 32). Each has 8 beats with dwen 1111; 16 dev reads at 0x0..0xF0; one finished pulse.
- MPS enc 2, host 0x0FF0, dev 0x100, len 64 -> (0x0FF0, len 4, 1 beat) then (0x1000, len 12, 3 beats). No request crosses 0x1000.
- host 0x2000, len 20 -> single request len 5 with 2 beats, dwen 1111 then 0001.
- len 0 -> finished one cycle after start; no dev_rd_valid or dma_write_valid ever asserted.
- Random dev_rd_ready stalls, 0-20 cycle response latency, toggling dma_write_data_ready, MPS enc 5 (capped at 512), len 4096:
  - 8 requests of len 128 each.
  - Payload equals the device address pattern, with no loss or duplication.
  - Buffer never exceeds 64 entries.
- Assert i_rst during DATA of the first chunk -> all outputs 0 on the next cycle. A new 64-byte transfer afterwards completes correctly, and stale responses are dropped.
